// File: rtl/park_gate_ctrl.sv
// ============================================================================
// park_gate_ctrl
// ----------------------------------------------------------------------------
// Purpose:
//   Gate sequencer in front of the `park` occupancy counter. Turns raw
//   entry/exit sensor levels into clean one-cycle car_entered / car_exited
//   events. The university-car qualifier is held stable for at least one
//   cycle before and after each event pulse, so `park` always samples a
//   settled class. Entries are admitted only when `park` reports a free space
//   of the requested class and the hour lies in [OPEN_HOUR, CLOSE_HOUR).
//   Exits are always admitted. Both barriers are held open for OPEN_CYCLES.
//
//   Each side runs its own FSM: IDLE -> SETUP -> PULSE -> OPEN -> HOLD -> IDLE.
//   A refused entry goes from IDLE straight to HOLD with a one-cycle
//   entry_denied pulse. HOLD waits for the request level to drop, so a car
//   that keeps its sensor asserted generates only one event.
//
// Parameters:
//   OPEN_CYCLES  barrier-open duration in clocks (>= 1)
//   OPEN_HOUR    first hour (0-23) in which entries are admitted
//   CLOSE_HOUR   first hour (1-24) in which entries are refused
//
// Ports:
//   clk                   in   system clock, rising edge
//   rst_n                 in   synchronous active-low reset
//   entry_req             in   entry sensor level
//   entry_is_uni          in   class of waiting entry car (1 = university)
//   exit_req              in   exit sensor level
//   exit_is_uni           in   class of exiting car
//   hour[4:0]             in   current hour, values > 23 count as closed
//   uni_is_vacated_space  in   park: university space free
//   is_vacated_space      in   park: general space free
//   car_entered           out  one-cycle entry event
//   is_uni_car_entered    out  entry class qualifier
//   car_exited            out  one-cycle exit event
//   is_uni_car_exited     out  exit class qualifier
//   entry_gate_open       out  entry barrier drive
//   exit_gate_open        out  exit barrier drive
//   entry_denied          out  one-cycle refusal pulse
//
// Optional build macro:
//   PARK_GATE_STATS_EN    adds saturating 16-bit counters entries_ok,
//                         entries_denied and exits_ok (cleared by rst_n).
// ============================================================================
module park_gate_ctrl #(
  parameter int OPEN_CYCLES = 8,
  parameter int OPEN_HOUR   = 8,
  parameter int CLOSE_HOUR  = 22
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        entry_req,
  input  logic        entry_is_uni,
  input  logic        exit_req,
  input  logic        exit_is_uni,
  input  logic [4:0]  hour,
  input  logic        uni_is_vacated_space,
  input  logic        is_vacated_space,
  output logic        car_entered,
  output logic        is_uni_car_entered,
  output logic        car_exited,
  output logic        is_uni_car_exited,
  output logic        entry_gate_open,
  output logic        exit_gate_open,
`ifdef PARK_GATE_STATS_EN
  output logic [15:0] entries_ok,
  output logic [15:0] entries_denied,
  output logic [15:0] exits_ok,
`endif
  output logic        entry_denied
);

  localparam int CNT_W = $clog2(OPEN_CYCLES + 1);
  // The counter is loaded on the PULSE->OPEN edge and OPEN ends on the edge
  // where it reads zero, so loading OPEN_CYCLES-1 gives OPEN_CYCLES cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_OPEN,
    S_HOLD
  } state_t;

  // --------------------------------------------------------------------------
  // Admission check (combinational, only consulted in entry IDLE)
  // --------------------------------------------------------------------------
  logic w_hour_ok;
  logic w_space_ok;
  logic w_admit;

  // hour > 23 is refused even if CLOSE_HOUR were configured above 24.
  assign w_hour_ok  = (int'(hour) >= OPEN_HOUR) &&
                      (int'(hour) <  CLOSE_HOUR) &&
                      (int'(hour) <= 23);
  assign w_space_ok = entry_is_uni ? uni_is_vacated_space : is_vacated_space;
  assign w_admit    = w_hour_ok && w_space_ok;

  // --------------------------------------------------------------------------
  // Entry FSM
  // --------------------------------------------------------------------------
  state_t           r_en_state;
  logic [CNT_W-1:0] r_en_cnt;
  logic             r_car_entered;
  logic             r_is_uni_car_entered;
  logic             r_entry_gate_open;
  logic             r_entry_denied;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_en_state           <= S_IDLE;
      r_en_cnt             <= CNT_ZERO;
      r_car_entered        <= 1'b0;
      r_is_uni_car_entered <= 1'b0;
      r_entry_gate_open    <= 1'b0;
      r_entry_denied       <= 1'b0;
    end else begin
      // Event and refusal outputs are single-cycle by default.
      r_car_entered  <= 1'b0;
      r_entry_denied <= 1'b0;
      unique case (r_en_state)
        S_IDLE: begin
          if (entry_req) begin
            if (w_admit) begin
              // Class is captured here; later input changes are ignored.
              r_is_uni_car_entered <= entry_is_uni;
              r_en_state           <= S_SETUP;
            end else begin
              r_entry_denied <= 1'b1;
              r_en_state     <= S_HOLD;
            end
          end
        end
        S_SETUP: begin
          r_car_entered <= 1'b1;
          r_en_state    <= S_PULSE;
        end
        S_PULSE: begin
          r_entry_gate_open <= 1'b1;
          r_en_cnt          <= CNT_LOAD;
          r_en_state        <= S_OPEN;
        end
        S_OPEN: begin
          if (r_en_cnt == CNT_ZERO) begin
            r_entry_gate_open    <= 1'b0;
            r_is_uni_car_entered <= 1'b0;
            r_en_state           <= S_HOLD;
          end else begin
            r_en_cnt <= r_en_cnt - CNT_ONE;
          end
        end
        S_HOLD: begin
          if (!entry_req) begin
            r_en_state <= S_IDLE;
          end
        end
        default: begin
          r_en_state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Exit FSM (same sequence, no admission check)
  // --------------------------------------------------------------------------
  state_t           r_ex_state;
  logic [CNT_W-1:0] r_ex_cnt;
  logic             r_car_exited;
  logic             r_is_uni_car_exited;
  logic             r_exit_gate_open;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_state          <= S_IDLE;
      r_ex_cnt            <= CNT_ZERO;
      r_car_exited        <= 1'b0;
      r_is_uni_car_exited <= 1'b0;
      r_exit_gate_open    <= 1'b0;
    end else begin
      r_car_exited <= 1'b0;
      unique case (r_ex_state)
        S_IDLE: begin
          if (exit_req) begin
            r_is_uni_car_exited <= exit_is_uni;
            r_ex_state          <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_car_exited <= 1'b1;
          r_ex_state   <= S_PULSE;
        end
        S_PULSE: begin
          r_exit_gate_open <= 1'b1;
          r_ex_cnt         <= CNT_LOAD;
          r_ex_state       <= S_OPEN;
        end
        S_OPEN: begin
          if (r_ex_cnt == CNT_ZERO) begin
            r_exit_gate_open    <= 1'b0;
            r_is_uni_car_exited <= 1'b0;
            r_ex_state          <= S_HOLD;
          end else begin
            r_ex_cnt <= r_ex_cnt - CNT_ONE;
          end
        end
        S_HOLD: begin
          if (!exit_req) begin
            r_ex_state <= S_IDLE;
          end
        end
        default: begin
          r_ex_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PARK_GATE_STATS_EN
  // --------------------------------------------------------------------------
  // Saturating event statistics
  // --------------------------------------------------------------------------
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] r_entries_ok;
  logic [15:0] r_entries_denied;
  logic [15:0] r_exits_ok;

  // Counters sample the registered pulses, so each count lands on the edge
  // that ends the pulse cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_entries_ok     <= 16'd0;
      r_entries_denied <= 16'd0;
      r_exits_ok       <= 16'd0;
    end else begin
      if (r_car_entered)  r_entries_ok     <= sat_inc(r_entries_ok);
      if (r_entry_denied) r_entries_denied <= sat_inc(r_entries_denied);
      if (r_car_exited)   r_exits_ok       <= sat_inc(r_exits_ok);
    end
  end

  assign entries_ok     = r_entries_ok;
  assign entries_denied = r_entries_denied;
  assign exits_ok       = r_exits_ok;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign car_entered        = r_car_entered;
  assign is_uni_car_entered = r_is_uni_car_entered;
  assign entry_gate_open    = r_entry_gate_open;
  assign entry_denied       = r_entry_denied;
  assign car_exited         = r_car_exited;
  assign is_uni_car_exited  = r_is_uni_car_exited;
  assign exit_gate_open     = r_exit_gate_open;

endmodule

// File: tb/tb_park_gate_ctrl.sv
// ============================================================================
// tb_park_gate_ctrl
// Directed, table-driven bench for park_gate_ctrl (default parameters:
// OPEN_CYCLES=8, OPEN_HOUR=8, CLOSE_HOUR=22). Inputs change on the falling
// edge and outputs are sampled on the falling edge. Cycle k of a vector is
// the interval after the k-th rising edge that sees the request.
// ============================================================================
module tb_park_gate_ctrl;

  logic       clk;
  logic       rst_n;
  logic       entry_req;
  logic       entry_is_uni;
  logic       exit_req;
  logic       exit_is_uni;
  logic [4:0] hour;
  logic       uni_is_vacated_space;
  logic       is_vacated_space;
  logic       car_entered;
  logic       is_uni_car_entered;
  logic       car_exited;
  logic       is_uni_car_exited;
  logic       entry_gate_open;
  logic       exit_gate_open;
  logic       entry_denied;
`ifdef PARK_GATE_STATS_EN
  logic [15:0] entries_ok;
  logic [15:0] entries_denied;
  logic [15:0] exits_ok;
`endif

  park_gate_ctrl dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .entry_req            (entry_req),
    .entry_is_uni         (entry_is_uni),
    .exit_req             (exit_req),
    .exit_is_uni          (exit_is_uni),
    .hour                 (hour),
    .uni_is_vacated_space (uni_is_vacated_space),
    .is_vacated_space     (is_vacated_space),
    .car_entered          (car_entered),
    .is_uni_car_entered   (is_uni_car_entered),
    .car_exited           (car_exited),
    .is_uni_car_exited    (is_uni_car_exited),
    .entry_gate_open      (entry_gate_open),
    .exit_gate_open       (exit_gate_open),
`ifdef PARK_GATE_STATS_EN
    .entries_ok           (entries_ok),
    .entries_denied       (entries_denied),
    .exits_ok             (exits_ok),
`endif
    .entry_denied         (entry_denied)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;      // entry_req asserted
    logic       en_uni;
    logic       ex;      // exit_req asserted
    logic       ex_uni;
    logic [4:0] hour;
    logic       uvac;
    logic       vac;
    logic       adm;     // hand-computed: entry admitted
    logic       scr;     // scramble side inputs after the decision edge
  } vec_t;

  localparam int NVEC = 13;
  vec_t tbl [NVEC];

  int n_checks;
  int n_fail;
  int exp_ok;
  int exp_den;
  int exp_ex;

  task automatic chk(input string nm, input int idx, input int cyc,
                     input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s vec=%0d cyc=%0d got=%0h want=%0h", nm, idx, cyc, got, want);
    end
  endtask

  // {car_entered, is_uni_car_entered, entry_gate_open, entry_denied,
  //  car_exited, is_uni_car_exited, exit_gate_open}
  function automatic logic [6:0] outs();
    return {car_entered, is_uni_car_entered, entry_gate_open, entry_denied,
            car_exited, is_uni_car_exited, exit_gate_open};
  endfunction

  // Expected timeline: qualifier cycles 0..9, pulse cycle 1, gate 2..9,
  // denial pulse cycle 0.
  function automatic logic [6:0] expv(input vec_t v, input int k);
    logic ce, eq, eg, ed, xe, xq, xg;
    ce = 1'b0; eq = 1'b0; eg = 1'b0; ed = 1'b0;
    xe = 1'b0; xq = 1'b0; xg = 1'b0;
    if (v.en && v.adm) begin
      ce = (k == 1);
      eq = (k <= 9) && v.en_uni;
      eg = (k >= 2) && (k <= 9);
    end else if (v.en) begin
      ed = (k == 0);
    end
    if (v.ex) begin
      xe = (k == 1);
      xq = (k <= 9) && v.ex_uni;
      xg = (k >= 2) && (k <= 9);
    end
    return {ce, eq, eg, ed, xe, xq, xg};
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    entry_req            = v.en;
    entry_is_uni         = v.en_uni;
    exit_req             = v.ex;
    exit_is_uni          = v.ex_uni;
    hour                 = v.hour;
    uni_is_vacated_space = v.uvac;
    is_vacated_space     = v.vac;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      chk("seq", idx, k, 32'(outs()), 32'(expv(v, k)));
      if (k == 0 && v.scr) begin
        entry_is_uni         = ~v.en_uni;
        exit_is_uni          = ~v.ex_uni;
        hour                 = 5'd31;
        uni_is_vacated_space = 1'b0;
        is_vacated_space     = 1'b0;
      end
    end
    entry_req = 1'b0;
    exit_req  = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after", idx, 99, 32'(outs()), 32'd0);
    if (v.en && v.adm)  exp_ok++;
    if (v.en && !v.adm) exp_den++;
    if (v.ex)           exp_ex++;
  endtask

  int pulses;

  initial begin
    n_checks = 0; n_fail = 0;
    exp_ok = 0; exp_den = 0; exp_ex = 0;

    //            en    en_uni ex    ex_uni hour   uvac  vac   adm   scr
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd7,  1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd8,  1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd22, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd25, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd21, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd12, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd15, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd23, 1'b1, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0;
    entry_req = 1'b0; entry_is_uni = 1'b0;
    exit_req = 1'b0;  exit_is_uni = 1'b0;
    hour = 5'd10;
    uni_is_vacated_space = 1'b0; is_vacated_space = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 0, 0, 32'(outs()), 32'd0);
    rst_n = 1'b1;

    // Reset in the middle of OPEN aborts; a still-held request restarts.
    entry_req = 1'b1; entry_is_uni = 1'b1; hour = 5'd10;
    uni_is_vacated_space = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_open_gate", 0, 4, 32'(entry_gate_open), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset_outs", 0, 0, 32'(outs()), 32'd0);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (car_entered) pulses++;
      if (k == 1) chk("restart_pulse", 0, k, 32'(car_entered), 32'd1);
      if (k == 2) chk("restart_gate", 0, k, 32'(entry_gate_open), 32'd1);
    end
    chk("restart_pulse_count", 0, 0, 32'(pulses), 32'd1);
    chk("restart_hold_outs", 0, 13, 32'(outs()), 32'd0);
    entry_req = 1'b0;
    repeat (3) @(negedge clk);
    exp_ok = 1;

    for (int i = 0; i < NVEC; i++) begin
      run_vec(i, tbl[i]);
    end

`ifdef PARK_GATE_STATS_EN
    chk("stats_entries_ok", 0, 0, 32'(entries_ok), 32'(exp_ok));
    chk("stats_entries_denied", 0, 0, 32'(entries_denied), 32'(exp_den));
    chk("stats_exits_ok", 0, 0, 32'(exits_ok), 32'(exp_ex));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("stats_cleared", 0, 0, 32'({entries_ok, entries_denied} | 32'(exits_ok)), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
